// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard between decode and write-back: tracks in-flight destinations
// and raises a combinational stall request when decode reads a register that is still pending.
module hazard_scoreboard #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic [4:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             forward_en,
    input  logic             freeze,
    input  logic             flush,
    output logic             hazard_detected,
    output logic [CNT_W-1:0] stall_count,
    output logic [DEPTH-1:0] occupancy
);

    // Entry 0 is EXE; entry DEPTH-1 is the last stage before write-back.
    logic [DEPTH-1:0] v_reg;
    logic [DEPTH-1:0] wb_reg;
    logic [DEPTH-1:0] ld_reg;
    logic [4:0]       dest_reg [DEPTH];

    logic [DEPTH-1:0] match_src1;
    logic [DEPTH-1:0] match_src2;
    logic             hazard_cond;
    logic             issue;
    logic [CNT_W-1:0] stall_count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Register 0 is hard-wired, so a write to it never creates a dependency.
            assign match_src1[gi] = v_reg[gi] & wb_reg[gi] & (dest_reg[gi] != 5'd0)
                                    & (dest_reg[gi] == id_src1);
            assign match_src2[gi] = v_reg[gi] & wb_reg[gi] & (dest_reg[gi] != 5'd0)
                                    & (dest_reg[gi] == id_src2);
            assign occupancy[gi]  = v_reg[gi] & wb_reg[gi];
        end
    endgenerate

    // With forwarding, only a load still in EXE cannot be bypassed in time.
    always_comb begin
        hazard_cond = 1'b0;
        if (forward_en) begin
            hazard_cond = ld_reg[0] & (match_src1[0] | match_src2[0]);
        end else begin
            hazard_cond = |(match_src1 | match_src2);
        end
    end

    assign hazard_detected = hazard_cond & id_valid & ~flush;
    assign issue           = id_valid & ~hazard_detected;
    assign stall_count     = stall_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg  <= '0;
            wb_reg <= '0;
            ld_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_reg[i] <= 5'd0;
            end
        end else if (flush) begin
            v_reg  <= '0;
            wb_reg <= '0;
            ld_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_reg[i] <= 5'd0;
            end
        end else if (!freeze) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                v_reg[i]    <= v_reg[i-1];
                wb_reg[i]   <= wb_reg[i-1];
                ld_reg[i]   <= ld_reg[i-1];
                dest_reg[i] <= dest_reg[i-1];
            end
            // A stalled or empty decode slot enters EXE as an all-zero bubble.
            v_reg[0]    <= issue;
            wb_reg[0]   <= issue & id_wb_en;
            ld_reg[0]   <= issue & id_mem_r_en;
            dest_reg[0] <= issue ? id_dest : 5'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else if (hazard_detected && !freeze && !(&stall_count_reg)) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, all checked against
// a queue-based model of the in-flight instruction list.
module tb_hazard_scoreboard;

    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_wb_en, id_mem_r_en, forward_en, freeze, flush;
    logic [4:0]       id_src1, id_src2, id_dest;
    logic             hazard_detected, hazard_small;
    logic [15:0]      stall_count;
    logic [3:0]       stall_count_small;
    logic [DEPTH-1:0] occupancy, occupancy_small;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        bit       v;
        bit       wb;
        bit       ld;
        bit [4:0] dest;
    } ent_t;

    ent_t pipe[$];           // index 0 = youngest (EXE)
    int   m_stalls = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .forward_en(forward_en), .freeze(freeze), .flush(flush),
        .hazard_detected(hazard_detected), .stall_count(stall_count), .occupancy(occupancy)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .forward_en(forward_en), .freeze(freeze), .flush(flush),
        .hazard_detected(hazard_small), .stall_count(stall_count_small),
        .occupancy(occupancy_small)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        ent_t z;
        z = '0;
        pipe.delete();
        for (int k = 0; k < DEPTH; k++) pipe.push_back(z);
    endfunction

    // Any older writer of a source register blocks decode unless forwarding can cover it,
    // which only fails for a load that has just entered EXE.
    function automatic bit model_hz();
        bit c;
        c = 1'b0;
        foreach (pipe[k]) begin
            if (pipe[k].v && pipe[k].wb && pipe[k].dest != 5'd0 &&
                (pipe[k].dest == id_src1 || pipe[k].dest == id_src2)) begin
                if (!forward_en) c = 1'b1;
                else if (k == 0 && pipe[k].ld) c = 1'b1;
            end
        end
        return c && id_valid && !flush;
    endfunction

    function automatic logic [DEPTH-1:0] model_occ();
        logic [DEPTH-1:0] o;
        o = '0;
        foreach (pipe[k]) o[k] = pipe[k].v & pipe[k].wb;
        return o;
    endfunction

    task automatic step(input string tag);
        bit               hz;
        ent_t             e;
        logic [DEPTH-1:0] occ;
        #1;
        hz  = model_hz();
        occ = model_occ();
        check({tag, "_hz"}, 32'(hazard_detected), 32'(hz));
        check({tag, "_hz_small"}, 32'(hazard_small), 32'(hz));
        check({tag, "_occ"}, 32'(occupancy), 32'(occ));
        check({tag, "_cnt"}, 32'(stall_count), (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
        check({tag, "_cnt_small"}, 32'(stall_count_small), (m_stalls > 15) ? 32'd15 : 32'(m_stalls));
        $display("cyc %0d %s v=%0b s1=%0d s2=%0d d=%0d wb=%0b ld=%0b fwd=%0b frz=%0b fl=%0b hz=%0b occ=%b cnt=%0d",
                 cyc, tag, id_valid, id_src1, id_src2, id_dest, id_wb_en, id_mem_r_en,
                 forward_en, freeze, flush, hazard_detected, occupancy, stall_count);
        if (flush) begin
            model_clear();
        end else if (!freeze) begin
            if (hz) m_stalls++;
            e = '0;
            if (id_valid && !hz) begin
                e.v = 1'b1; e.wb = id_wb_en; e.ld = id_mem_r_en; e.dest = id_dest;
            end
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic wb, input logic ld);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
    endtask

    task automatic drain();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (DEPTH) step("drain");
    endtask

    int unsigned hold_cnt;

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; forward_en = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        model_clear();
        #1;
        check("rst_hz", 32'(hazard_detected), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_cnt", 32'(stall_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // No forwarding: two-cycle stall behind a producer in EXE
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); step("t2_prod");
        drive(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0); #1;
        check("t2_hz_a", 32'(hazard_detected), 32'd1);
        step("t2_c1");
        check("t2_hz_b", 32'(hazard_detected), 32'd1);
        step("t2_c2");
        check("t2_hz_c", 32'(hazard_detected), 32'd0);
        check("t2_cnt", 32'(stall_count), 32'd2);
        step("t2_c3");
        check("t2_enter", 32'(occupancy), 32'b01);
        drain();

        // Forwarding: load-use stalls one cycle, ALU result never stalls
        forward_en = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1); step("t3_load");
        drive(1'b1, 5'd0, 5'd5, 5'd8, 1'b1, 1'b0); #1;
        check("t3_ld_hz_a", 32'(hazard_detected), 32'd1);
        step("t3_lu1");
        check("t3_ld_hz_b", 32'(hazard_detected), 32'd0);
        step("t3_lu2");
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step("t3_alu");
        drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0); #1;
        check("t3_alu_hz_a", 32'(hazard_detected), 32'd0);
        step("t3_au1");
        check("t3_alu_hz_b", 32'(hazard_detected), 32'd0);
        forward_en = 1'b0;
        drain();

        // Register 0 never creates a dependency
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); step("t4_prod");
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
        check("t4_hz_a", 32'(hazard_detected), 32'd0);
        step("t4_c1");
        check("t4_hz_b", 32'(hazard_detected), 32'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("t4_c2"); step("t4_c3");
        check("t4_occ", 32'(occupancy), 32'd0);

        // Freeze holds the stall and the counter
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); step("t5_prod");
        drive(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0); step("t5_c1");
        hold_cnt = 32'(m_stalls);
        freeze = 1'b1;
        repeat (4) begin
            step("t5_frz");
            check("t5_frz_hz", 32'(hazard_detected), 32'd1);
            check("t5_frz_occ", 32'(occupancy), 32'b10);
            check("t5_frz_cnt", 32'(stall_count), hold_cnt);
        end
        freeze = 1'b0;
        step("t5_res");
        check("t5_res_hz", 32'(hazard_detected), 32'd0);
        step("t5_enter");

        // Flush squashes an active stall
        drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0); step("t6_prod");
        drive(1'b1, 5'd6, 5'd0, 5'd1, 1'b1, 1'b0);
        flush = 1'b1; #1;
        check("t6_fl_hz", 32'(hazard_detected), 32'd0);
        step("t6_flush");
        flush = 1'b0;
        check("t6_fl_occ", 32'(occupancy), 32'd0);
        drain();

        // Back-to-back stalls push the narrow counter into saturation
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0); step("t6_sp");
            drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
            repeat (3) step("t6_sc");
        end
        check("t6_sat", 32'(stall_count_small), 32'd15);

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0); step("rr_prod");
        drive(1'b1, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0); #1;
        check("rr_pre_hz", 32'(hazard_detected), 32'd1);
        rst = 1'b1; #1;
        check("rr_hz", 32'(hazard_detected), 32'd0);
        check("rr_occ", 32'(occupancy), 32'd0);
        check("rr_cnt", 32'(stall_count), 32'd0);
        check("rr_cnt_small", 32'(stall_count_small), 32'd0);
        model_clear();
        m_stalls = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Random traffic over a small register window to provoke frequent dependencies
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 15) == 0) forward_en = ~forward_en;
            freeze = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 15) == 0);
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
